// File: rtl/store_buffer.sv
// Store buffer between the MEM-stage byte-enable generator and the data memory port.
// Small FIFO with youngest-entry coalescing, req/gnt drain and load-hazard detection.
module store_buffer #(
  parameter int XLEN  = 32,
  parameter int DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       st_valid,
  input  logic [XLEN-1:0]            st_addr,
  input  logic [XLEN-1:0]            st_wdata,
  input  logic [XLEN/8-1:0]          st_be,
  output logic                       st_ready,
  input  logic                       ld_valid,
  input  logic [XLEN-1:0]            ld_addr,
  output logic                       ld_hazard,
  output logic                       mem_req,
  output logic [XLEN-1:0]            mem_addr,
  output logic [XLEN-1:0]            mem_wdata,
  output logic [XLEN/8-1:0]          mem_be,
  input  logic                       mem_gnt,
  output logic [$clog2(DEPTH):0]     count,
  output logic                       empty
);

  localparam int LB  = XLEN / 8;
  localparam int OFF = $clog2(LB);
  localparam int PW  = $clog2(DEPTH);
  localparam int CW  = PW + 1;
  localparam int WW  = XLEN - OFF;

  logic [PW-1:0]   head, tail, tail_m1;
  logic [CW-1:0]   cnt;
  logic [DEPTH-1:0] vld;
  logic [WW-1:0]   widx  [DEPTH];
  logic [XLEN-1:0] wdat  [DEPTH];
  logic [LB-1:0]   wbe   [DEPTH];

  logic [WW-1:0] st_word, ld_word;
  logic          full, coalesce_hit, accept, push_new, merge, pop, ld_match;
  logic          unused_lsbs;

  assign st_word = st_addr[XLEN-1:OFF];
  assign ld_word = ld_addr[XLEN-1:OFF];
  assign unused_lsbs = ^{st_addr[OFF-1:0], ld_addr[OFF-1:0]};

  assign tail_m1 = tail - 1'b1;
  assign full    = (cnt == CW'(DEPTH));
  // Needing two entries guarantees the merge target is never the head being presented.
  assign coalesce_hit = (cnt >= CW'(2)) && (widx[tail_m1] == st_word);
  assign st_ready     = !full || coalesce_hit;

  assign accept   = st_valid && st_ready && (|st_be);
  assign push_new = accept && !coalesce_hit;
  assign merge    = accept && coalesce_hit;

  assign mem_req   = (cnt != '0);
  assign pop       = mem_req && mem_gnt;
  assign mem_addr  = {widx[head], {OFF{1'b0}}};
  assign mem_wdata = wdat[head];
  assign mem_be    = wbe[head];

  assign count = cnt;
  assign empty = (cnt == '0);

  always_comb begin
    ld_match = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      if (vld[i] && (widx[i] == ld_word)) ld_match = 1'b1;
    end
  end

  assign ld_hazard = ld_valid && ld_match;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      head <= '0;
      tail <= '0;
      cnt  <= '0;
      vld  <= '0;
    end else begin
      if (pop) begin
        head      <= head + 1'b1;
        vld[head] <= 1'b0;
      end
      if (push_new) begin
        tail      <= tail + 1'b1;
        vld[tail] <= 1'b1;
      end
      case ({push_new, pop})
        2'b10:   cnt <= cnt + 1'b1;
        2'b01:   cnt <= cnt - 1'b1;
        default: cnt <= cnt;
      endcase
    end
  end

  // Payload needs no reset; valid bits and count qualify it.
  always_ff @(posedge clk) begin
    if (push_new) begin
      widx[tail] <= st_word;
      wdat[tail] <= st_wdata;
      wbe[tail]  <= st_be;
    end else if (merge) begin
      for (int i = 0; i < LB; i++) begin
        if (st_be[i]) wdat[tail_m1][8*i +: 8] <= st_wdata[8*i +: 8];
      end
      wbe[tail_m1] <= wbe[tail_m1] | st_be;
    end
  end

endmodule

// File: tb/tb_store_buffer.sv
// Directed bench for store_buffer: drain handshake, coalescing, full/ready, hazards, wrap, reset.
module tb_store_buffer;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        st_valid;
  logic [31:0] st_addr, st_wdata;
  logic [3:0]  st_be;
  logic        st_ready;
  logic        ld_valid;
  logic [31:0] ld_addr;
  logic        ld_hazard;
  logic        mem_req;
  logic [31:0] mem_addr, mem_wdata;
  logic [3:0]  mem_be;
  logic        mem_gnt;
  logic [2:0]  count;
  logic        empty;

  int nvec = 0;
  int nmis = 0;

  always #5 clk = ~clk;

  store_buffer #(.XLEN(32), .DEPTH(4)) dut (
    .clk(clk), .rst_n(rst_n),
    .st_valid(st_valid), .st_addr(st_addr), .st_wdata(st_wdata), .st_be(st_be),
    .st_ready(st_ready),
    .ld_valid(ld_valid), .ld_addr(ld_addr), .ld_hazard(ld_hazard),
    .mem_req(mem_req), .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_be(mem_be),
    .mem_gnt(mem_gnt), .count(count), .empty(empty)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    nvec++;
    if (obs !== exp) begin
      nmis++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [31:0] a, input logic [3:0] be, input logic [31:0] d);
    st_valid = 1'b1; st_addr = a; st_be = be; st_wdata = d;
    tick();
    st_valid = 1'b0;
  endtask

  initial begin
    rst_n = 1'b0; st_valid = 1'b0; st_addr = '0; st_wdata = '0; st_be = '0;
    ld_valid = 1'b0; ld_addr = '0; mem_gnt = 1'b0;
    #12;
    chk("rst_mem_req", mem_req, 0);
    chk("rst_empty", empty, 1);
    chk("rst_count", count, 0);
    chk("rst_ld_hazard", ld_hazard, 0);
    @(negedge clk); rst_n = 1'b1;
    tick();
    chk("rst_st_ready", st_ready, 1);

    // single store, held without grant, then drained
    push(32'h100, 4'b0001, 32'h0000_00AA);
    chk("a_req", mem_req, 1);
    chk("a_addr", mem_addr, 32'h100);
    chk("a_be", mem_be, 4'b0001);
    chk("a_byte0", mem_wdata[7:0], 8'hAA);
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("a_hold_req", mem_req, 1);
      chk("a_hold_addr", mem_addr, 32'h100);
      chk("a_hold_data", mem_wdata, 32'h0000_00AA);
      chk("a_hold_be", mem_be, 4'b0001);
    end
    mem_gnt = 1'b1; tick(); mem_gnt = 1'b0;
    chk("a_empty", empty, 1);
    chk("a_req_off", mem_req, 0);

    // coalesce into youngest
    push(32'h200, 4'b0011, 32'h1111_2222);
    push(32'h204, 4'b1111, 32'hAABB_CCDD);
    push(32'h206, 4'b1100, 32'h5566_0000);
    chk("b_count", count, 2);
    chk("b_head_addr", mem_addr, 32'h200);
    chk("b_head_be", mem_be, 4'b0011);
    mem_gnt = 1'b1; tick();
    chk("b_2nd_addr", mem_addr, 32'h204);
    chk("b_2nd_data", mem_wdata, 32'h5566_CCDD);
    chk("b_2nd_be", mem_be, 4'b1111);
    tick(); mem_gnt = 1'b0;
    chk("b_empty", empty, 1);

    // fill, full refusal, merge while full, no pop->push pass-through
    push(32'h400, 4'hF, 32'h400);
    push(32'h404, 4'hF, 32'h404);
    push(32'h408, 4'hF, 32'h408);
    push(32'h40C, 4'hF, 32'h40C);
    chk("c_full_count", count, 4);
    st_valid = 1'b1; st_addr = 32'h410; st_be = 4'hF; st_wdata = 32'h410;
    #1 chk("c_full_ready", st_ready, 0);
    st_addr = 32'h40C; st_be = 4'b0001; st_wdata = 32'h0000_0077;
    #1 chk("c_merge_ready", st_ready, 1);
    tick();
    chk("c_merge_count", count, 4);
    st_addr = 32'h410; st_be = 4'hF; st_wdata = 32'h410; mem_gnt = 1'b1;
    #1 chk("c_gnt_ready", st_ready, 0);
    tick();
    mem_gnt = 1'b0;
    chk("c_refused_count", count, 3);
    chk("c_retry_ready", st_ready, 1);
    tick();
    st_valid = 1'b0;
    chk("c_accept_count", count, 4);
    mem_gnt = 1'b1;
    chk("c_d0_addr", mem_addr, 32'h404); tick();
    chk("c_d1_addr", mem_addr, 32'h408); tick();
    chk("c_d2_addr", mem_addr, 32'h40C);
    chk("c_d2_data", mem_wdata, 32'h0000_0477); tick();
    chk("c_d3_addr", mem_addr, 32'h410); tick();
    mem_gnt = 1'b0;
    chk("c_empty", empty, 1);

    // load hazards
    push(32'h300, 4'hF, 32'h1);
    push(32'h308, 4'hF, 32'h2);
    ld_valid = 1'b1; ld_addr = 32'h30A;
    #1 chk("d_hit", ld_hazard, 1);
    ld_addr = 32'h304;
    #1 chk("d_miss", ld_hazard, 0);
    ld_addr = 32'h302; mem_gnt = 1'b1;
    #1 chk("d_head_gnt_hit", ld_hazard, 1);
    tick(); tick(); mem_gnt = 1'b0;
    ld_addr = 32'h30A;
    #1 chk("d_drained", ld_hazard, 0);
    ld_valid = 1'b0;

    // zero-enable store is dropped
    st_valid = 1'b1; st_addr = 32'h500; st_be = 4'b0000; st_wdata = 32'hFFFF_FFFF;
    #1 chk("e_zero_ready", st_ready, 1);
    tick(); st_valid = 1'b0;
    chk("e_zero_count", count, 0);
    chk("e_zero_req", mem_req, 0);

    // push and grant every cycle, pointers wrap
    push(32'h600, 4'hF, 32'h600);
    chk("e_stream_start", count, 1);
    for (int i = 1; i <= 10; i++) begin
      st_valid = 1'b1; st_addr = 32'h600 + 32'(4*i); st_be = 4'hF; st_wdata = st_addr;
      mem_gnt = 1'b1;
      #1 chk("e_stream_addr", mem_addr, 32'h600 + 32'(4*(i-1)));
      tick();
      chk("e_stream_count", count, 1);
    end
    st_valid = 1'b0;
    chk("e_last_addr", mem_addr, 32'h628);
    tick(); mem_gnt = 1'b0;
    chk("e_empty", empty, 1);

    // reset mid-drain
    push(32'h700, 4'hF, 32'h7);
    push(32'h704, 4'hF, 32'h8);
    push(32'h708, 4'hF, 32'h9);
    chk("f_pre_count", count, 3);
    chk("f_pre_req", mem_req, 1);
    ld_valid = 1'b1; ld_addr = 32'h704;
    #1 chk("f_pre_hazard", ld_hazard, 1);
    rst_n = 1'b0;
    #1;
    chk("f_rst_req", mem_req, 0);
    chk("f_rst_count", count, 0);
    chk("f_rst_empty", empty, 1);
    chk("f_rst_hazard", ld_hazard, 0);
    @(negedge clk); rst_n = 1'b1; ld_valid = 1'b0;
    tick();
    chk("f_post_ready", st_ready, 1);
    chk("f_post_empty", empty, 1);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nmis);
    $finish;
  end

endmodule

// File: doc/store_buffer.md
Name: store_buffer

Overview:
- Write-side queue between the MEM-stage byte-enable generator and the data memory port.
- Accepts lane-aligned store data plus per-byte enables from the pipeline and holds them in a small FIFO.
- Drains entries to memory through a req/gnt handshake.
- Coalesces same-word stores into the youngest entry.
- Flags load hazards against pending stores so the hazard unit can stall.

Parameters:
- XLEN, 32, data/address width in bits; byte lanes = XLEN/8.
- DEPTH, 4, number of entries; power of two, >= 2.

Ports:
- clk  input  1  clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- st_valid  input  1  store offered by MEM stage this cycle.
- st_addr  input  XLEN  store byte address; only word index addr[XLEN-1:$clog2(XLEN/8)] is used.
- st_wdata  input  XLEN  store data, already placed on its byte lanes.
- st_be  input  XLEN/8  byte enables from the MEM stage.
- st_ready  output  1  store accepted when st_valid && st_ready.
- ld_valid  input  1  load in MEM stage this cycle.
- ld_addr  input  XLEN  load byte address.
- ld_hazard  output  1  load word matches a pending entry.
- mem_req  output  1  head entry presented to memory.
- mem_addr  output  XLEN  head word address, low $clog2(XLEN/8) bits zero.
- mem_wdata  output  XLEN  head data.
- mem_be  output  XLEN/8  head byte enables.
- mem_gnt  input  1  memory accepts head this cycle.
- count  output  $clog2(DEPTH)+1  number of valid entries.
- empty  output  1  count == 0.

Behaviour:
- Reset (async, rst_n low):
  - Head/tail pointers, count, and all entry valid bits go to 0. Entry payloads are don't-care.
  - Outputs: mem_req=0, empty=1, count=0, ld_hazard=0.
  - st_ready is 1 once out of reset.
  - Reset mid-drain discards all entries, including one being requested; memory must tolerate the aborted req.
- Entry contents: word index, XLEN data, XLEN/8 enables.
- Push, on st_valid && st_ready:
  - st_be == 0: the store is accepted and dropped. No state change.
  - Coalesce hit: count >= 2 and the youngest entry (tail-1) has the same word index as st_addr. The entry is updated lane-wise: for each i with st_be[i]=1, data byte i = st_wdata byte i and be[i] = 1. No new slot is used.
  - The head is never coalesced into, even if it is the youngest entry. This keeps mem_* stable while mem_req is high.
  - Otherwise the store is written at tail, tail increments (wraps mod DEPTH), and count increments.
- st_ready = !full || coalesce_hit. Combinational from current state and st_addr.
- A pop in the same cycle does not free space for a push; no pass-through from pop to push.
- Drain:
  - mem_req = !empty. mem_addr/mem_wdata/mem_be come from the head, driven combinationally from registers.
  - mem_* must stay stable while mem_req=1 && mem_gnt=0.
  - Pop on mem_req && mem_gnt: head increments (wraps), count decrements.
  - mem_gnt while mem_req=0 is ignored.
- Simultaneous push (new slot) and pop: count unchanged, both pointers advance.
- Simultaneous coalesce and pop: allowed, because coalescing requires count >= 2, so the target is never the head.
- Latency: a store pushed in cycle N makes mem_req high in cycle N+1 at the earliest. Entries drain at most one per cycle.
- ld_hazard:
  - Combinational: ld_valid && (any valid entry word index == ld_addr word index).
  - Byte enables are ignored for the comparison (conservative).
  - The head still counts during its grant cycle.
  - A store being pushed in the same cycle is not compared.
- Ordering: strict FIFO. Memory sees words in program order except where coalescing merges them.
- count and empty are derived from registered state; no glitch on push/pop in the same cycle.

Test Plan:
- Reset with rst_n=0 mid-run while count=3 and mem_req=1 -> mem_req=0, count=0, empty=1 immediately; after release, st_ready=1.
- Push sb to 0x100 with be=0001 and data 0x000000AA, mem_gnt=0 -> next cycle mem_req=1, mem_addr=0x100, mem_be=0001, mem_wdata byte0=0xAA. Hold 3 cycles -> mem_* unchanged. Grant -> empty=1 the following cycle.
- With mem_gnt=0, push 0x200 be=0011, then 0x204 be=1111, then 0x206 be=1100 -> count=2 (third store coalesced into 0x204, bytes 2-3 overwritten); head stays 0x200 with be=0011.
- Fill to DEPTH=4 with distinct words and mem_gnt=0 -> st_ready=0 for a new word. A store to the youngest word's address -> st_ready=1 and it merges. Assert mem_gnt alongside a new-word push while full -> push is refused that cycle and accepted the next.
- Entries at 0x300 and 0x308, ld_valid with ld_addr=0x30A -> ld_hazard=1. ld_addr=0x304 -> ld_hazard=0. After both drain, ld_addr=0x30A -> ld_hazard=0.
- Push with st_be=0000 -> st_ready=1, count unchanged, no mem_req. Push and grant every cycle for 10 cycles -> count stays 1 and pointers wrap correctly (addresses issued in order).
